// File: rtl/hubris_uart_boot_loader.sv
// UART boot loader: receives a framed, checksummed program image, writes it into core memory,
// then releases the Hubris core from reset. Optional idle-gap timeout: `define BOOT_LOADER_TIMEOUT_EN.
module hubris_uart_boot_loader #(
    parameter int unsigned CLK_PER_BAUD   = 54,
    parameter int unsigned MAX_PROG_BYTES = 4096,
    parameter logic [31:0] LOAD_BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        core_reset,
    output logic        core_rx,
    output logic        boot_done,
    output logic        boot_error
);
    localparam int unsigned CNT_W  = $clog2(MAX_PROG_BYTES) + 1;
    localparam int unsigned BAUD_W = $clog2(CLK_PER_BAUD) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BAUD - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLK_PER_BAUD / 2 - 1);
    localparam logic [7:0] MAGIC = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_MAGIC, LEN, DATA, CSUM, DONE, ERROR} boot_state_t;

    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_t         rx_state, rx_state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        rx_byte;
    logic              baud_tick, half_tick, byte_valid, frame_err;

    assign baud_tick = (baud_cnt == BAUD_LAST);
    assign half_tick = (baud_cnt == HALF_LAST);

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        rx_state_next = rx_state;
        byte_valid    = 1'b0;
        frame_err     = 1'b0;
        unique case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_state_next = RX_START;
            RX_START: if (half_tick) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (baud_tick && bit_cnt == 3'd7) rx_state_next = RX_STOP;
            RX_STOP: begin
                if (baud_tick) begin
                    rx_state_next = RX_IDLE;
                    byte_valid    = rx_sync;
                    frame_err     = !rx_sync;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            rx_byte  <= '0;
        end else begin
            rx_state <= rx_state_next;
            // Counter restarts on every state change so START measures a half bit and DATA/STOP full bits.
            if (rx_state == RX_IDLE || rx_state != rx_state_next || baud_tick)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + BAUD_W'(1);
            if (rx_state != RX_DATA)
                bit_cnt <= '0;
            else if (baud_tick)
                bit_cnt <= bit_cnt + 3'd1;
            if (rx_state == RX_DATA && baud_tick)
                rx_byte <= {rx_sync, rx_byte[7:1]};
        end
    end

    boot_state_t      state, state_next;
    logic [23:0]      len_sr, word_sr;
    logic [31:0]      len_full;
    logic [CNT_W-1:0] len_q, byte_cnt;
    logic [7:0]       csum;
    logic             last_byte, timeout;

    assign len_full  = {rx_byte, len_sr};
    assign last_byte = ((byte_cnt + CNT_W'(1)) == len_q);

`ifdef BOOT_LOADER_TIMEOUT_EN
    logic [31:0] gap_cnt;
    logic        loading;

    assign loading = (state == LEN) || (state == DATA) || (state == CSUM);
    assign timeout = loading && (gap_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            gap_cnt <= '0;
        else if (!loading || byte_valid)
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + 32'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            WAIT_MAGIC, ERROR: if (byte_valid && rx_byte == MAGIC) state_next = LEN;
            LEN: begin
                if (frame_err)
                    state_next = ERROR;
                else if (byte_valid && byte_cnt[1:0] == 2'd3) begin
                    if (len_full[1:0] != 2'b00 || len_full > 32'(MAX_PROG_BYTES))
                        state_next = ERROR;
                    else if (len_full == 32'd0)
                        state_next = CSUM;
                    else
                        state_next = DATA;
                end
            end
            DATA: begin
                if (frame_err)
                    state_next = ERROR;
                else if (byte_valid && last_byte)
                    state_next = CSUM;
            end
            CSUM: begin
                if (frame_err)
                    state_next = ERROR;
                else if (byte_valid)
                    state_next = (rx_byte == csum) ? DONE : ERROR;
            end
            DONE:    state_next = DONE;
            default: state_next = ERROR;
        endcase
        if (timeout) state_next = ERROR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= WAIT_MAGIC;
            len_sr     <= '0;
            word_sr    <= '0;
            len_q      <= '0;
            byte_cnt   <= '0;
            csum       <= '0;
            mem_en     <= 1'b0;
            mem_addr   <= LOAD_BASE_ADDR;
            mem_din    <= '0;
            core_reset <= 1'b1;
            boot_done  <= 1'b0;
            boot_error <= 1'b0;
        end else begin
            state      <= state_next;
            mem_en     <= 1'b0;
            core_reset <= ~boot_done;
            if (mem_en) mem_addr <= mem_addr + 32'd4;
            if (state_next == ERROR) boot_error <= 1'b1;
            if (state_next == DONE) boot_done <= 1'b1;
            unique case (state)
                WAIT_MAGIC, ERROR: begin
                    if (state_next == LEN) begin
                        boot_error <= 1'b0;
                        csum       <= '0;
                        byte_cnt   <= '0;
                        mem_addr   <= LOAD_BASE_ADDR;
                    end
                end
                LEN: begin
                    if (byte_valid) begin
                        len_sr   <= {rx_byte, len_sr[23:8]};
                        len_q    <= len_full[CNT_W-1:0];
                        byte_cnt <= (byte_cnt[1:0] == 2'd3) ? '0 : byte_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        csum     <= csum + rx_byte;
                        word_sr  <= {rx_byte, word_sr[23:8]};
                        // Little-endian word is complete on the 4th byte; strobe next cycle.
                        if (byte_cnt[1:0] == 2'd3) begin
                            mem_en  <= 1'b1;
                            mem_din <= {rx_byte, word_sr};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we  = {4{mem_en}};
    assign core_rx = boot_done ? rx_sync : 1'b1;

endmodule

// File: doc/hubris_uart_boot_loader.md
Name: hubris_uart_boot_loader

Overview:
- Sits upstream of the Hubris core and shares its program memory.
- Receives a program image over UART after reset and writes it word-by-word into memory through a write-only port. That port is muxed onto core memory port A externally, with selection by core_reset.
- Holds the core in reset (active-high, as the core expects) until the image is loaded and its checksum passes.
- After loading, passes the rx line through to the core's io_input_rx.

Parameters:
- CLK_PER_BAUD, 54, clk cycles per UART bit (921600 baud at 50 MHz).
- MAX_PROG_BYTES, 4096, largest accepted image length in bytes.
- LOAD_BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- TIMEOUT_CYCLES, 5_000_000, idle-gap limit used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; 0 = reset.
- rx  in  1  UART serial input; idle high.
- mem_en  out  1  memory write strobe.
- mem_we  out  4  byte write enables; 4'hF when mem_en=1, else 0.
- mem_addr  out  32  byte address, word aligned.
- mem_din  out  32  write data, little-endian assembled.
- core_reset  out  1  active-high reset to the Hubris core.
- core_rx  out  1  rx passthrough to the core; forced 1 until boot_done.
- boot_done  out  1  image loaded and verified (sticky).
- boot_error  out  1  last load attempt failed.

Behaviour:
- Reset values (reset=0): mem_en=0, mem_we=0, mem_addr=LOAD_BASE_ADDR, mem_din=0, core_reset=1, core_rx=1, boot_done=0, boot_error=0, FSM=WAIT_MAGIC, all counters 0.
- Asserting reset mid-load aborts immediately. Memory contents already written are left as-is.
- UART RX input conditioning: rx passes through a 2-flop synchroniser.
- UART RX start bit: a falling edge arms the start bit; it is re-checked low at CLK_PER_BAUD/2. If it is high, treat as a glitch and return to idle.
- UART RX data: 8 data bits, LSB first, each sampled at mid-bit.
- UART RX stop bit: sampled at mid-bit.
- UART RX output: produces a one-cycle byte_valid with an 8-bit byte.
- UART RX framing error: stop bit sampled 0.
- Frame format: magic 0xA5; then LEN as 4 bytes little-endian; then LEN payload bytes; then CSUM byte.
- Checksum rule: CSUM = 8-bit sum of payload bytes mod 256.
- FSM state WAIT_MAGIC: byte 0xA5 moves to LEN and clears boot_error, the checksum accumulator and the byte counter. Other bytes and framing errors are ignored.
- FSM state LEN: after the 4th byte, length is checked.
  - LEN[1:0]!=0 or LEN>MAX_PROG_BYTES -> ERROR.
  - LEN==0 -> CSUM.
  - Otherwise -> DATA.
- FSM state DATA: each byte is shifted into bits [8k+7:8k] of the word assembly register, with k = byte index mod 4, and added to the accumulator.
  - On the 4th byte of a word: mem_en=1 for exactly one cycle, the cycle after byte_valid; mem_din = assembled word; mem_addr = LOAD_BASE_ADDR + 4*word_index.
  - mem_addr increments after each write.
  - After the last payload byte's write -> CSUM.
- FSM state CSUM: a received byte equal to the accumulator -> DONE; otherwise -> ERROR.
- FSM state DONE: boot_done=1; core_reset drops to 0 one cycle after boot_done rises; core_rx = rx (synchronised).
  - DONE is terminal until reset; later bytes are not interpreted.
- FSM state ERROR: boot_error=1 and core_reset stays 1. It behaves as WAIT_MAGIC, so a new 0xA5 restarts the load.
- A framing error in LEN, DATA or CSUM -> ERROR.
- Accumulator width is 8 bits with wrap-around. Byte counter width is clog2(MAX_PROG_BYTES)+1 bits.
- At most one memory write per 10 bit-times, so there is no back-pressure and no FIFO.

Optional Feature:
- Macro BOOT_LOADER_TIMEOUT_EN.
- Defined: a gap counter resets on every byte_valid and runs in LEN, DATA and CSUM. Reaching TIMEOUT_CYCLES -> ERROR.
- Not defined: no counter exists; the FSM waits indefinitely for the next byte.

Test Plan:
- Send A5, 08 00 00 00, 13 00 00 00 93 00 10 00, CSUM=0xB6 -> two writes: addr 0x0 din 0x0000_0013, then addr 0x4 din 0x0010_0093; each mem_we=4'hF for 1 cycle; then boot_done=1, core_reset=0 one cycle later, core_rx follows rx.
- Same frame with CSUM=0xB7 -> boot_error=1, core_reset=1, boot_done=0. Resend the correct frame -> boot_error clears on A5, boot_done=1.
- LEN=6 (06 00 00 00) and LEN=MAX_PROG_BYTES+4 -> ERROR right after the 4th LEN byte; no mem_en pulse.
- LEN=0 followed by CSUM 0x00 -> boot_done=1 with zero writes.
- Pre-magic noise 0x00 0xFF plus a 1/4-bit low glitch on rx -> stays in WAIT_MAGIC. A stop-bit-low byte inside DATA -> ERROR.
- Drop reset low during DATA after the 1st word -> all outputs return to reset values asynchronously. With BOOT_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=1000, stalling 1000 cycles mid-DATA -> boot_error=1.
